// File: rtl/fwd_scoreboard.sv
// ============================================================================
// fwd_scoreboard : EX-stage operand forwarding with a one-entry retire buffer
//                  and a pending-register scoreboard for one multi-cycle unit.
// Optional macro : FWD_PERF_CNT_EN (stall-cycle counter on stallCount)
// Revision       : 1.0
// ============================================================================
`default_nettype none

module fwd_scoreboard #(
   parameter int NUM_READ   = 2,
   parameter int NUM_STAGES = 2,
   parameter int REG_W      = 5,
   parameter int DATA_W     = 32
) (
   input  logic                         clk,
   input  logic                         resetN,
   input  logic [NUM_READ*REG_W-1:0]    rdReg,
   input  logic [NUM_READ-1:0]          rdUse,
   input  logic [NUM_STAGES*REG_W-1:0]  stgWriteReg,
   input  logic [NUM_STAGES-1:0]        stgDataValid,
   input  logic [NUM_STAGES*DATA_W-1:0] stgData,
   input  logic                         mcStart,
   input  logic [REG_W-1:0]             mcDest,
   input  logic                         mcDone,
   input  logic [REG_W-1:0]             mcDoneReg,
   input  logic [DATA_W-1:0]            mcData,
   output logic [NUM_READ-1:0]          fwd,
   output logic [NUM_READ*DATA_W-1:0]   fwdData,
   output logic                         stall,
   output logic                         mcBusy,
   output logic [31:0]                  stallCount
);

   localparam int NUM_REGS = 2 ** REG_W;
   localparam int OLDEST   = NUM_STAGES - 1;

   logic [NUM_REGS-1:0] pending_q, pending_d;
   logic                busy_q, busy_d;
   logic                retValid_q;
   logic [REG_W-1:0]    retReg_q;
   logic [DATA_W-1:0]   retData_q;
   logic [NUM_READ-1:0] w_portStall;

   // A completion retires before a same-cycle start, so a start can be accepted
   // on the cycle the previous op finishes.
   always_comb begin
      logic w_clr;
      w_clr     = mcDone && busy_q;
      pending_d = pending_q;
      busy_d    = busy_q && !w_clr;
      if (w_clr) pending_d[mcDoneReg] = 1'b0;
      if (mcStart && !busy_d) begin
         busy_d = 1'b1;
         if (mcDest != '0) pending_d[mcDest] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pending_q  <= '0;
         busy_q     <= 1'b0;
         retValid_q <= 1'b0;
         retReg_q   <= '0;
         retData_q  <= '0;
      end else begin
         pending_q  <= pending_d;
         busy_q     <= busy_d;
         retValid_q <= (stgWriteReg[OLDEST*REG_W +: REG_W] != '0);
         retReg_q   <= stgWriteReg[OLDEST*REG_W +: REG_W];
         retData_q  <= stgData[OLDEST*DATA_W +: DATA_W];
      end
   end

   for (genvar p = 0; p < NUM_READ; p++) begin : g_port
      logic [REG_W-1:0]  w_reg;
      logic              w_fwd;
      logic              w_stall;
      logic [DATA_W-1:0] w_data;

      assign w_reg = rdReg[p*REG_W +: REG_W];

      // The youngest matching stage owns the register; an unready result
      // there must stall rather than fall through to stale older copies.
      always_comb begin
         logic w_hit;
         w_hit   = 1'b0;
         w_fwd   = 1'b0;
         w_stall = 1'b0;
         w_data  = '0;
         if (rdUse[p] && (w_reg != '0)) begin
            if (mcDone && (mcDoneReg == w_reg)) begin
               w_fwd  = 1'b1;
               w_data = mcData;
            end else begin
               for (int s = 0; s < NUM_STAGES; s++) begin
                  if (!w_hit && (stgWriteReg[s*REG_W +: REG_W] == w_reg)) begin
                     w_hit = 1'b1;
                     if (stgDataValid[s]) begin
                        w_fwd  = 1'b1;
                        w_data = stgData[s*DATA_W +: DATA_W];
                     end else begin
                        w_stall = 1'b1;
                     end
                  end
               end
               if (!w_hit) begin
                  if (pending_q[w_reg]) begin
                     w_stall = 1'b1;
                  end else if (retValid_q && (retReg_q == w_reg)) begin
                     w_fwd  = 1'b1;
                     w_data = retData_q;
                  end
               end
            end
         end
      end

      assign fwd[p]                       = w_fwd;
      assign fwdData[p*DATA_W +: DATA_W]  = w_data;
      assign w_portStall[p]               = w_stall;
   end

   assign stall  = |w_portStall;
   assign mcBusy = busy_q;

`ifdef FWD_PERF_CNT_EN
   logic [31:0] stallCount_q;
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN)    stallCount_q <= '0;
      else if (stall) stallCount_q <= stallCount_q + 32'd1;
   end
   assign stallCount = stallCount_q;
`else
   assign stallCount = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
// ============================================================================
// tb_fwd_scoreboard : directed + random scoreboard bench for fwd_scoreboard
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_fwd_scoreboard;

   localparam int NR = 2;
   localparam int NS = 2;
   localparam int RW = 5;
   localparam int DW = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Unpacked stimulus, packed onto the DUT's flattened buses below.
   logic          resetN;
   logic [RW-1:0] t_rd  [NR];
   logic          t_use [NR];
   logic [RW-1:0] t_wr  [NS];
   logic          t_vld [NS];
   logic [DW-1:0] t_dat [NS];
   logic          mcStart, mcDone;
   logic [RW-1:0] mcDest, mcDoneReg;
   logic [DW-1:0] mcData;

   logic [NR*RW-1:0] rdReg;
   logic [NR-1:0]    rdUse;
   logic [NS*RW-1:0] stgWriteReg;
   logic [NS-1:0]    stgDataValid;
   logic [NS*DW-1:0] stgData;

   always_comb begin
      rdReg = '0; rdUse = '0; stgWriteReg = '0; stgDataValid = '0; stgData = '0;
      for (int p = 0; p < NR; p++) begin
         rdReg[p*RW +: RW] = t_rd[p];
         rdUse[p]          = t_use[p];
      end
      for (int s = 0; s < NS; s++) begin
         stgWriteReg[s*RW +: RW] = t_wr[s];
         stgDataValid[s]         = t_vld[s];
         stgData[s*DW +: DW]     = t_dat[s];
      end
   end

   logic [NR-1:0]    fwd;
   logic [NR*DW-1:0] fwdData;
   logic             stall, mcBusy;
   logic [31:0]      stallCount;

   fwd_scoreboard #(.NUM_READ(NR), .NUM_STAGES(NS), .REG_W(RW), .DATA_W(DW)) dut (
      .clk(clk), .resetN(resetN), .rdReg(rdReg), .rdUse(rdUse),
      .stgWriteReg(stgWriteReg), .stgDataValid(stgDataValid), .stgData(stgData),
      .mcStart(mcStart), .mcDest(mcDest), .mcDone(mcDone), .mcDoneReg(mcDoneReg),
      .mcData(mcData), .fwd(fwd), .fwdData(fwdData), .stall(stall),
      .mcBusy(mcBusy), .stallCount(stallCount)
   );

   // Reference model: architectural state as plain arrays.
   bit            m_pend [2**RW];
   bit            m_busy;
   bit            m_retV;
   logic [RW-1:0] m_retR;
   logic [DW-1:0] m_retD;
   logic [31:0]   m_cnt;

   typedef struct {
      logic [NR-1:0]    fwd;
      logic [NR*DW-1:0] data;
      logic             stall;
      logic             busy;
      logic [31:0]      cnt;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk = 0;
   int   n_fail = 0;

   task automatic model_clear();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_busy = 0; m_retV = 0; m_retR = '0; m_retD = '0; m_cnt = '0;
   endtask

   function automatic exp_t predict();
      exp_t e;
      e.fwd = '0; e.data = '0; e.stall = 1'b0; e.busy = m_busy; e.cnt = m_cnt;
      for (int p = 0; p < NR; p++) begin
         int owner;
         if (!t_use[p] || t_rd[p] == '0) continue;
         if (mcDone && mcDoneReg == t_rd[p]) begin
            e.fwd[p] = 1'b1; e.data[p*DW +: DW] = mcData;
            continue;
         end
         owner = -1;
         for (int s = NS - 1; s >= 0; s--) if (t_wr[s] == t_rd[p]) owner = s;
         if (owner >= 0) begin
            if (t_vld[owner]) begin
               e.fwd[p] = 1'b1; e.data[p*DW +: DW] = t_dat[owner];
            end else e.stall = 1'b1;
         end else if (m_pend[t_rd[p]]) e.stall = 1'b1;
         else if (m_retV && m_retR == t_rd[p]) begin
            e.fwd[p] = 1'b1; e.data[p*DW +: DW] = m_retD;
         end
      end
      return e;
   endfunction

   task automatic model_edge(input logic was_stall);
      if (!resetN) begin model_clear(); return; end
`ifdef FWD_PERF_CNT_EN
      if (was_stall) m_cnt = m_cnt + 1;
`endif
      if (mcDone && m_busy) begin m_pend[mcDoneReg] = 0; m_busy = 0; end
      if (mcStart && !m_busy) begin
         m_busy = 1;
         if (mcDest != 0) m_pend[mcDest] = 1;
      end
      m_retV = (t_wr[NS-1] != 0); m_retR = t_wr[NS-1]; m_retD = t_dat[NS-1];
   endtask

   // One cycle: inputs are already applied; predict, let the monitor check at
   // the falling edge, then advance the model on the rising edge.
   task automatic cycle();
      if (!resetN) model_clear();
      cur = predict();
      exp_q.push_back(cur);
      @(posedge clk);
      model_edge(cur.stall);
      #1;
   endtask

   task automatic idle_in();
      for (int p = 0; p < NR; p++) begin t_rd[p] = '0; t_use[p] = 1'b0; end
      for (int s = 0; s < NS; s++) begin t_wr[s] = '0; t_vld[s] = 1'b1; t_dat[s] = '0; end
      mcStart = 0; mcDest = '0; mcDone = 0; mcDoneReg = '0; mcData = '0;
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk("fwd",        128'(fwd),        128'(e.fwd));
         chk("fwdData",    128'(fwdData),    128'(e.data));
         chk("stall",      128'(stall),      128'(e.stall));
         chk("mcBusy",     128'(mcBusy),     128'(e.busy));
         chk("stallCount", 128'(stallCount), 128'(e.cnt));
      end
   end

   initial begin
      resetN = 1'b0;
      idle_in();
      model_clear();
      @(posedge clk); #1;
      cycle();                       // reset state
      resetN = 1'b1;
      cycle();

      // Youngest stage wins
      t_wr[0] = 8; t_dat[0] = 32'h11; t_wr[1] = 8; t_dat[1] = 32'h22;
      t_rd[0] = 8; t_use[0] = 1; cycle();

      // Load-use stall, then resolved from the older stage
      idle_in(); t_wr[0] = 9; t_vld[0] = 0; t_wr[1] = 9; t_dat[1] = 32'h33;
      t_rd[1] = 9; t_use[1] = 1; cycle();
      t_wr[0] = 0; t_vld[0] = 1; t_dat[1] = 32'h44; cycle();

      // Multi-cycle op: reads stall until completion forwards mcData
      idle_in(); mcStart = 1; mcDest = 10; cycle();
      mcStart = 0; t_rd[0] = 10; t_use[0] = 1;
      repeat (5) cycle();
      mcDone = 1; mcDoneReg = 10; mcData = 32'hDEAD; cycle();
      mcDone = 0; cycle();

      // Retire buffer covers the register-file write-to-read gap
      idle_in(); t_wr[1] = 12; t_dat[1] = 32'h55; cycle();
      t_wr[1] = 0; t_rd[0] = 12; t_use[0] = 1; cycle();
      t_use[0] = 0; cycle();
      t_use[0] = 1; t_rd[0] = 0; cycle();

      // Start while busy is ignored; reset mid-op; later done is ignored
      idle_in(); mcStart = 1; mcDest = 20; cycle();
      mcDest = 3; cycle();
      mcStart = 0; t_rd[0] = 3; t_use[0] = 1; t_rd[1] = 20; t_use[1] = 1; cycle();
      resetN = 1'b0; cycle();
      resetN = 1'b1; mcDone = 1; mcDoneReg = 20; t_use[0] = 0; t_use[1] = 0; cycle();
      mcDone = 0; t_use[1] = 1; cycle();

      // Seven consecutive stall cycles
      idle_in(); t_wr[0] = 5; t_vld[0] = 0; t_rd[0] = 5; t_use[0] = 1;
      repeat (7) cycle();

      // Randomised traffic over a small register window to force collisions
      for (int n = 0; n < 400; n++) begin
         resetN = ($urandom_range(0, 99) != 0);
         for (int p = 0; p < NR; p++) begin
            t_rd[p] = RW'($urandom_range(0, 7)); t_use[p] = ($urandom_range(0, 3) != 0);
         end
         for (int s = 0; s < NS; s++) begin
            t_wr[s] = RW'($urandom_range(0, 7)); t_vld[s] = ($urandom_range(0, 3) != 0);
            t_dat[s] = $urandom;
         end
         mcStart   = ($urandom_range(0, 5) == 0);
         mcDest    = RW'($urandom_range(0, 7));
         mcDone    = m_busy ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         mcDoneReg = RW'($urandom_range(0, 7));
         mcData    = $urandom;
         cycle();
      end
      idle_in(); resetN = 1'b1;
      @(negedge clk);
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the EX-stage forwarding logic: N read ports, D bypass stages, a one-entry retire buffer, and a pending-register scoreboard for one multi-cycle unit (MUL/DIV).
- Sits beside the EX stage.
- Outputs per-port forward select and data, plus a single stall request to the hazard/PC control.

Parameters:
- NUM_READ, 2, number of consumer read ports (rs, rt, ...).
- NUM_STAGES, 2, number of bypass stages. Index 0 is the youngest (MEM); index NUM_STAGES-1 is the oldest (WB).
- REG_W, 5, register index width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- resetN  in  1  asynchronous, active-low reset.
- rdReg  in  NUM_READ*REG_W  consumer register indices, flattened, port p at [p*REG_W +: REG_W].
- rdUse  in  NUM_READ  port p actually reads its register.
- stgWriteReg  in  NUM_STAGES*REG_W  destination register per bypass stage; 0 = no write.
- stgDataValid  in  NUM_STAGES  stage result already available (0 for a load still in MEM).
- stgData  in  NUM_STAGES*DATA_W  stage result (ALU out, link PC or memory data, muxed upstream).
- mcStart  in  1  multi-cycle op issued this cycle.
- mcDest  in  REG_W  destination of the issued multi-cycle op.
- mcDone  in  1  multi-cycle result available this cycle.
- mcDoneReg  in  REG_W  destination of the completing op.
- mcData  in  DATA_W  multi-cycle result.
- fwd  out  NUM_READ  port p takes fwdData instead of the register-file value.
- fwdData  out  NUM_READ*DATA_W  forwarded data per port.
- stall  out  1  EX must hold this cycle.
- mcBusy  out  1  a multi-cycle op is outstanding.
- stallCount  out  32  stall-cycle counter (see Optional Feature).

Behaviour:
- Reset (async, resetN=0):
  - pending[] = 0, retire buffer invalid, mcBusy = 0, stallCount = 0.
  - fwd and stall are combinational and evaluate to 0 once state is clear.
- fwd, fwdData and stall are combinational from current inputs and state. Zero latency.
- Per port p, the forward decision is suppressed (fwd=0, no stall contribution) when rdUse[p]=0 or rdReg[p]=0.
- Per-port source priority, first match wins:
  1. mcDone && mcDoneReg==rdReg[p] -> forward mcData.
  2. Lowest-index stage s with stgWriteReg[s]==rdReg[p]:
     - stgDataValid[s]=1 -> forward stgData[s].
     - stgDataValid[s]=0 -> port stalls. Never fall through to older stages.
  3. pending[rdReg[p]]=1 -> port stalls.
  4. Retire buffer valid and retReg==rdReg[p] -> forward retData.
  5. Otherwise fwd[p]=0.
- stall = OR over all port stalls. fwdData[p] is don't-care when fwd[p]=0; drive 0.
- fwdData must be 0 whenever stall=1 for that port.
- Scoreboard (32-entry pending vector, 2^REG_W entries), updated on posedge:
  - mcStart && !mcBusy && mcDest!=0 -> set pending[mcDest], mcBusy <= 1.
  - mcStart with mcDest==0 -> mcBusy <= 1 only (HI/LO-only ops).
  - mcDone -> clear pending[mcDoneReg], mcBusy <= 0.
  - mcDone and mcStart in the same cycle: the clear happens first, then the set. A start to the same register leaves it pending; a new op is accepted.
  - mcStart while mcBusy && !mcDone -> ignored. Upstream must not issue it; the bench checks that pending is unchanged.
  - mcDone while !mcBusy -> ignored. No state change.
- Retire buffer, updated on posedge:
  - Captures {stgWriteReg[NUM_STAGES-1], stgData[NUM_STAGES-1]}, valid = (reg!=0).
  - Updates every cycle regardless of stall. WB always retires.
  - Covers register files without write-through (write at posedge, read in the following cycle).
- Reset asserted mid-operation clears pending and mcBusy immediately. A later mcDone is ignored.

Optional Feature:
- Macro: FWD_PERF_CNT_EN.
- Defined: stallCount increments by 1 on every posedge where stall=1. Wraps 0xFFFFFFFF -> 0. Cleared by reset.
- Not defined: stallCount tied to 0; no counter flop is synthesised.

Test Plan:
1. Stage0 writeReg=8, dataValid=1, data=0x11; stage1 writeReg=8, data=0x22; rdReg[0]=8 -> fwd[0]=1, fwdData=0x11 (youngest wins), stall=0.
2. Load-use: stage0 writeReg=9, dataValid=0; stage1 writeReg=9, data=0x33; rdReg[1]=9 -> stall=1, fwd[1]=0. Next cycle stage1 writeReg=9, dataValid=1, data=0x44 -> fwdData=0x44, stall=0.
3. mcStart, mcDest=10 -> mcBusy=1. Reads of reg 10 stall for 5 cycles. mcDone, mcDoneReg=10, mcData=0xDEAD in the same cycle as the read -> fwd=1, fwdData=0xDEAD, stall=0. Next cycle pending[10]=0.
4. Retire buffer: stage1 writeReg=12, data=0x55. Next cycle no stage matches and rdReg=12 -> fwd=1, fwdData=0x55. rdReg=0 or rdUse=0 -> fwd=0.
5. mcStart for reg 3 while busy -> pending[3] stays 0. resetN pulsed low mid-op -> mcBusy=0, pending cleared, subsequent mcDone ignored.
6. With FWD_PERF_CNT_EN defined: 7 stall cycles -> stallCount=7. Preload to 0xFFFFFFFF, one stall -> 0. Without the macro -> stallCount always 0.
